datapath_top: RTL and testbench
===============================

// Module: datapath_top
// PURPOSE
//  16-bit microprogrammed datapath: 8-entry register file, operand muxes, ALU/shifter function unit and status flags.
//  Driven each cycle by a 55-bit control word from the sequencer/pattern source.
//  Exposes all registers, both operand buses and the flags for observation.
// PARAMETERS
//  none (width 16, 8 registers, 55-bit control word are fixed)
// PORTS
//  clk         in   1   single system clock; all state updates on rising edge
//  rst         in   1   asynchronous, active-high reset
//  ControlWord in   55  control word, fields below
//  V,C,N,Z     out  1   registered flags: overflow, carry, negative, zero
//  r0..r7      out  16  register file contents R0..R7
//  A           out  16  A operand bus
//  B           out  16  B operand bus (after constant mux)
// BEHAVIOUR
//  Control word fields:
//   [54:52] DA  destination reg | [51:49] AA  A-source reg | [48:46] BA  B-source reg
//   [45]    MB  1 = B bus takes CONST | [44:41] FS function select | [40] MD 1 = write DIN, 0 = write F
//   [39]    RW  register write enable | [38:23] CONST | [22:7] DIN external data
//   [6:3]   SH  shift amount 0..15 | [2:0] reserved, ignored
//  Combinational: A = R[AA]; B = MB ? CONST : R[BA]; F = FU(FS, A, B, SH).
//  FS, arithmetic: 17-bit sum {C,F} = A + Y + cin.
//   0 A (Y=0,cin=0) | 1 A+1 | 2 A+B | 3 A+B+1 | 4 A+~B | 5 A-B (A+~B+1)
//   6 A-1 (Y=FFFF,cin=0) | 7 A (Y=0,cin=0)
//   C = bit 16 of the sum; V = (A[15]==Y[15]) && (F[15]!=A[15]).
//  FS, logic/shift (V=0, C=0):
//   8 A&B | 9 A|B | A A^B | B ~A | C B | D B>>SH logical | E B<<SH logical | F B>>>SH arithmetic
//  All FS: N = F[15]; Z = (F == 0).
//  Rising clk, every cycle: {V,C,N,Z} <= flags of F (independent of RW).
//   If RW: R[DA] <= MD ? DIN : F.
//  Register writes and flag updates are visible one clock after the control word is applied.
//  A/B/F are combinational from the current control word and current registers.
//  Same register as source and destination: the source reads the old value; the new value lands at the edge.
//  Wrap-around: arithmetic results are modulo 2^16. FFFF+1 -> 0000, C=1, Z=1.
//  rst asserted (any time, asynchronous): R0..R7 = 0 and V=C=N=Z=0 immediately. A and B then follow the zeroed registers.
//  Reset held: no writes, regardless of RW.
//  Release: normal operation from the next rising edge.
// TESTING
//  1. Reset then load: rst pulse; DA=1, MD=1, RW=1, DIN=0x1234 -> r1=0x1234 after edge; all others 0; flags 0.
//  2. Constant add: R1=0x1234, AA=1, MB=1, CONST=0x0001, FS=2, DA=2, RW=1
//     -> r2=0x1235; B=0x0001; V=C=N=Z=0.
//  3. Overflow/carry: R1=0x7FFF, R2=0x0001, FS=2 -> F=0x8000, V=1, N=1, C=0.
//     R1=0xFFFF, FS=1 -> F=0, C=1, Z=1.
//  4. Subtract: R1=5, R2=5, FS=5 -> F=0, Z=1, C=1.
//     R1=3, R2=5 -> F=0xFFFE, N=1, C=0.
//  5. Logic and shift: A=0xF0F0, B=0x0FF0 -> FS=8 gives 0x00F0, FS=A gives 0xFF00.
//     B=0x8001: SH=4, FS=F -> 0xF800; FS=D -> 0x0800; FS=E, SH=1 -> 0x0002.
//  6. RW=0 with DA=3 -> r3 unchanged while flags still update.
//     rst asserted mid-sequence -> all r*/flags zero without waiting for clk.

Source files
------------

// File: rtl/datapath_top.sv
// 16-bit microprogrammed datapath: 8x16 register file,
// operand muxes, ALU/shifter function unit, registered flags.
module datapath_top (
  input  logic        clk,
  input  logic        rst,
  input  logic [54:0] ControlWord,
  output logic        V,
  output logic        C,
  output logic        N,
  output logic        Z,
  output logic [15:0] r0,
  output logic [15:0] r1,
  output logic [15:0] r2,
  output logic [15:0] r3,
  output logic [15:0] r4,
  output logic [15:0] r5,
  output logic [15:0] r6,
  output logic [15:0] r7,
  output logic [15:0] A,
  output logic [15:0] B
);

  logic [15:0] r_rf [8];
  logic [3:0]  r_fl;

  logic [2:0]  w_da;
  logic [2:0]  w_aa;
  logic [2:0]  w_ba;
  logic        w_mb;
  logic [3:0]  w_fs;
  logic        w_md;
  logic        w_rw;
  logic [15:0] w_const;
  logic [15:0] w_din;
  logic [3:0]  w_sh;
  logic        w_unused;

  logic [15:0] w_a;
  logic [15:0] w_b;
  logic [15:0] w_y;
  logic        w_cin;
  logic [16:0] w_sum;
  logic [15:0] w_f;
  logic        w_v;
  logic        w_c;

  assign w_da     = ControlWord[54:52];
  assign w_aa     = ControlWord[51:49];
  assign w_ba     = ControlWord[48:46];
  assign w_mb     = ControlWord[45];
  assign w_fs     = ControlWord[44:41];
  assign w_md     = ControlWord[40];
  assign w_rw     = ControlWord[39];
  assign w_const  = ControlWord[38:23];
  assign w_din    = ControlWord[22:7];
  assign w_sh     = ControlWord[6:3];
  assign w_unused = ^ControlWord[2:0];

  assign w_a = r_rf[w_aa];
  assign w_b = w_mb ? w_const : r_rf[w_ba];

  // Function unit: adder operand select, then arith or logic/shift result.
  always_comb begin
    w_y   = '0;
    w_cin = 1'b0;
    w_f   = '0;
    w_v   = 1'b0;
    w_c   = 1'b0;
    case (w_fs[2:0])
      3'd1: w_cin = 1'b1;
      3'd2: w_y = w_b;
      3'd3: begin
        w_y   = w_b;
        w_cin = 1'b1;
      end
      3'd4: w_y = ~w_b;
      3'd5: begin
        w_y   = ~w_b;
        w_cin = 1'b1;
      end
      3'd6: w_y = 16'hFFFF;
      default: ;
    endcase
    w_sum = {1'b0, w_a} + {1'b0, w_y} + {16'b0, w_cin};
    if (!w_fs[3]) begin
      w_f = w_sum[15:0];
      w_c = w_sum[16];
      w_v = (w_a[15] == w_y[15]) && (w_f[15] != w_a[15]);
    end else begin
      case (w_fs[2:0])
        3'd0: w_f = w_a & w_b;
        3'd1: w_f = w_a | w_b;
        3'd2: w_f = w_a ^ w_b;
        3'd3: w_f = ~w_a;
        3'd4: w_f = w_b;
        3'd5: w_f = w_b >> w_sh;
        3'd6: w_f = w_b << w_sh;
        default: w_f = 16'($signed(w_b) >>> w_sh);
      endcase
    end
  end

  // Flags track F every cycle, whether or not a register is written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_fl <= '0;
    else     r_fl <= {w_v, w_c, w_f[15], (w_f == 16'h0)};
  end

  // Register file write port: DIN or F into R[DA].
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) r_rf[i] <= '0;
    end else if (w_rw) begin
      r_rf[w_da] <= w_md ? w_din : w_f;
    end
  end

  assign {V, C, N, Z} = r_fl;
  assign A  = w_a;
  assign B  = w_b;
  assign r0 = r_rf[0];
  assign r1 = r_rf[1];
  assign r2 = r_rf[2];
  assign r3 = r_rf[3];
  assign r4 = r_rf[4];
  assign r5 = r_rf[5];
  assign r6 = r_rf[6];
  assign r7 = r_rf[7];

endmodule

// File: tb/tb_datapath_top.sv
// Testbench for datapath_top: scoreboard of expected
// register/flag results retired one clock after each control word.
module tb_datapath_top;

  logic        clk;
  logic        rst;
  logic [54:0] ControlWord;
  logic        V, C, N, Z;
  logic [15:0] r0, r1, r2, r3, r4, r5, r6, r7;
  logic [15:0] A, B;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string       tag;
    int          ri;
    logic [15:0] rv;
    logic [3:0]  fl;
  } exp_t;

  exp_t sb[$];

  datapath_top dut (
    .clk(clk), .rst(rst), .ControlWord(ControlWord),
    .V(V), .C(C), .N(N), .Z(Z),
    .r0(r0), .r1(r1), .r2(r2), .r3(r3),
    .r4(r4), .r5(r5), .r6(r6), .r7(r7),
    .A(A), .B(B)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] rsel(input int i);
    case (i)
      0: return r0;
      1: return r1;
      2: return r2;
      3: return r3;
      4: return r4;
      5: return r5;
      6: return r6;
      default: return r7;
    endcase
  endfunction

  function automatic logic [54:0] mk(
    input logic [2:0] da, input logic [2:0] aa, input logic [2:0] ba,
    input logic mb, input logic [3:0] fs, input logic md,
    input logic rw, input logic [15:0] k, input logic [15:0] din,
    input logic [3:0] sh);
    return {da, aa, ba, mb, fs, md, rw, k, din, sh, 3'b000};
  endfunction

  // Apply a control word and queue what it should produce.
  task automatic drive(input string tag, input logic [54:0] cw,
                       input int ri, input logic [15:0] rv,
                       input logic [3:0] fl);
    exp_t e;
    @(negedge clk);
    ControlWord = cw;
    e.tag = tag;
    e.ri  = ri;
    e.rv  = rv;
    e.fl  = fl;
    sb.push_back(e);
    #1;
  endtask

  // Let the edge happen, then retire the oldest expectation.
  task automatic retire();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 16'd1, 16'd0);
    end else begin
      e = sb.pop_front();
      chk({e.tag, "_r"}, rsel(e.ri), e.rv);
      chk({e.tag, "_f"}, {12'b0, V, C, N, Z}, {12'b0, e.fl});
    end
  endtask

  // Load via DIN; F = CONST(1) so flags come out 0.
  task automatic ld(input string tag, input logic [2:0] r,
                    input logic [15:0] v);
    drive(tag, mk(r, 3'd0, 3'd0, 1'b1, 4'hC, 1'b1, 1'b1,
                  16'h0001, v, 4'd0), int'(r), v, 4'b0000);
    retire();
  endtask

  task automatic op(input string tag, input logic [2:0] da,
                    input logic [2:0] aa, input logic [2:0] ba,
                    input logic [3:0] fs, input logic [3:0] sh,
                    input logic [15:0] rv, input logic [3:0] fl);
    drive(tag, mk(da, aa, ba, 1'b0, fs, 1'b0, 1'b1,
                  16'h0, 16'h0, sh), int'(da), rv, fl);
    retire();
  endtask

  initial begin
    logic [15:0] rv [8];
    ControlWord = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) chk($sformatf("rst_r%0d", i), rsel(i), 16'h0);
    chk("rst_flags", {12'b0, V, C, N, Z}, 16'h0);
    @(negedge clk);
    rst = 1'b0;

    // Reset then load.
    ld("load_r1", 3'd1, 16'h1234);
    chk("load_r0", r0, 16'h0);
    chk("load_r2", r2, 16'h0);

    // Constant add, combinational buses checked before the edge.
    drive("cadd", mk(3'd2, 3'd1, 3'd0, 1'b1, 4'h2, 1'b0, 1'b1,
                     16'h0001, 16'h0, 4'd0), 2, 16'h1235, 4'b0000);
    chk("cadd_A", A, 16'h1234);
    chk("cadd_B", B, 16'h0001);
    retire();

    // Overflow and carry.
    ld("ld7fff", 3'd1, 16'h7FFF);
    ld("ld0001", 3'd2, 16'h0001);
    op("ovf", 3'd3, 3'd1, 3'd2, 4'h2, 4'd0, 16'h8000, 4'b1010);
    ld("ldffff", 3'd1, 16'hFFFF);
    op("wrap", 3'd3, 3'd1, 3'd0, 4'h1, 4'd0, 16'h0000, 4'b0101);

    // Subtract.
    ld("ld5a", 3'd1, 16'd5);
    ld("ld5b", 3'd2, 16'd5);
    op("sub0", 3'd4, 3'd1, 3'd2, 4'h5, 4'd0, 16'h0000, 4'b0101);
    ld("ld3", 3'd1, 16'd3);
    op("subn", 3'd4, 3'd1, 3'd2, 4'h5, 4'd0, 16'hFFFE, 4'b0010);
    op("addc", 3'd4, 3'd1, 3'd2, 4'h3, 4'd0, 16'h0009, 4'b0000);
    op("anb", 3'd4, 3'd1, 3'd2, 4'h4, 4'd0, 16'hFFFD, 4'b0010);

    // Logic and shifts.
    ld("ldf0f0", 3'd1, 16'hF0F0);
    ld("ld0ff0", 3'd2, 16'h0FF0);
    op("and", 3'd5, 3'd1, 3'd2, 4'h8, 4'd0, 16'h00F0, 4'b0000);
    op("xor", 3'd5, 3'd1, 3'd2, 4'hA, 4'd0, 16'hFF00, 4'b0010);
    op("or", 3'd5, 3'd1, 3'd2, 4'h9, 4'd0, 16'hFFF0, 4'b0010);
    op("not", 3'd5, 3'd1, 3'd2, 4'hB, 4'd0, 16'h0F0F, 4'b0000);
    ld("ld8001", 3'd2, 16'h8001);
    op("asr4", 3'd5, 3'd1, 3'd2, 4'hF, 4'd4, 16'hF800, 4'b0010);
    op("lsr4", 3'd5, 3'd1, 3'd2, 4'hD, 4'd4, 16'h0800, 4'b0000);
    op("lsl1", 3'd5, 3'd1, 3'd2, 4'hE, 4'd1, 16'h0002, 4'b0000);
    op("lsl15", 3'd5, 3'd1, 3'd2, 4'hE, 4'd15, 16'h8000, 4'b0010);
    op("pass", 3'd5, 3'd1, 3'd0, 4'h7, 4'd0, 16'hF0F0, 4'b0010);

    // RW=0: r3 (currently 0) holds while flags take F = CONST.
    drive("norw", mk(3'd3, 3'd0, 3'd0, 1'b1, 4'hC, 1'b0, 1'b0,
                     16'h8000, 16'h0, 4'd0), 3, 16'h0000, 4'b0010);
    retire();

    // Source and destination the same register.
    ld("ld0010", 3'd6, 16'h0010);
    drive("inc6", mk(3'd6, 3'd6, 3'd0, 1'b0, 4'h1, 1'b0, 1'b1,
                     16'h0, 16'h0, 4'd0), 6, 16'h0011, 4'b0000);
    chk("inc6_A", A, 16'h0010);
    retire();
    op("dec6", 3'd6, 3'd6, 3'd0, 4'h6, 4'd0, 16'h0010, 4'b0100);

    // Random loads through every destination.
    for (int i = 0; i < 8; i++) begin
      rv[i] = 16'($urandom);
      ld($sformatf("rnd_r%0d", i), 3'(i), rv[i]);
    end
    for (int i = 0; i < 8; i++) chk($sformatf("rnd_hold%0d", i), rsel(i), rv[i]);

    // Asynchronous reset between edges.
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) chk($sformatf("arst_r%0d", i), rsel(i), 16'h0);
    chk("arst_flags", {12'b0, V, C, N, Z}, 16'h0);

    // Writes are blocked while reset is held.
    @(negedge clk);
    ControlWord = mk(3'd1, 3'd1, 3'd0, 1'b1, 4'hC, 1'b1, 1'b1,
                     16'h0001, 16'hBEEF, 4'd0);
    @(posedge clk);
    #1;
    chk("hold_r1", r1, 16'h0);
    chk("hold_A", A, 16'h0);
    chk("hold_flags", {12'b0, V, C, N, Z}, 16'h0);
    @(negedge clk);
    rst = 1'b0;
    ld("post_rst", 3'd1, 16'hBEEF);

    chk("sb_drained", 16'(sb.size()), 16'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
